spi_dac_tx: RTL

SPI_DAC_TX -- requirements
Module: spi_dac_tx

---
 rtl/spi_dac_tx_pkg.sv | 30 +++
 rtl/spi_dac_tx_clk_gen.sv | 51 +++++
 rtl/spi_dac_tx.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_dac_tx_pkg.sv
// Shared definitions for the SPI audio DAC transmitter: frame geometry,
// FSM encoding and the frame-building helper.
package spi_dac_tx_pkg;

    localparam int FRAME_W  = 16;
    localparam int SAMPLE_W = 12;
    localparam int CTRL_W   = FRAME_W - SAMPLE_W;
    localparam int DIV_W    = 8;

    localparam logic [CTRL_W-1:0] CTRL_DEFAULT = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // Offset binary is two's complement with the sign bit inverted.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CTRL_W-1:0]   ctrl,
        input logic [SAMPLE_W-1:0] smp,
        input bit                  offset_bin
    );
        logic [SAMPLE_W-1:0] d;
        d = smp;
        if (offset_bin) d[SAMPLE_W-1] = ~smp[SAMPLE_W-1];
        return {ctrl, d};
    endfunction

endpackage

// File: rtl/spi_dac_tx_clk_gen.sv
// Serial clock divider: sclk level plus one-cycle strobes for the clk edge
// on which sclk is about to rise or fall.
module spi_clk_gen
    import spi_dac_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    assign tc     = en_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_o = tc && !sclk_q;
    assign fall_o = tc &&  sclk_q;
    assign sclk_o = sclk_q;

    // Disabled means parked: counter at zero and sclk low, so every frame
    // starts with a full low half-period.
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_dac_tx.sv
// SPI transmitter for a 16-bit DAC word {CTRL, sample}: accepts one sample,
// shifts it MSB first with cs_n low, then holds cs_n high for a fixed gap.
module spi_dac_tx
    import spi_dac_tx_pkg::*;
#(
    parameter int unsigned       CLK_DIV    = 4,
    parameter int unsigned       GAP_CYC    = 4,
    parameter bit                OFFSET_BIN = 1'b1,
    parameter logic [CTRL_W-1:0] CTRL       = CTRL_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                sclk_o,
    output logic                cs_n_o,
    output logic                mosi_o,
    output logic                busy_o,
    output logic                done_o
);

    state_e             state_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [4:0]         rise_cnt_q;
    logic [DIV_W-1:0]   gap_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               cs_n_q;

    logic sclk_en;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_en = (state_q == ST_SHIFT);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .en_i  (sclk_en),
        .sclk_o(sclk_o),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            rise_cnt_q <= '0;
            gap_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        state_q    <= ST_SHIFT;
                        shreg_q    <= build_frame(CTRL, sample_i, OFFSET_BIN);
                        rise_cnt_q <= '0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) rise_cnt_q <= rise_cnt_q + 5'd1;
                    // The fall after the 16th rise closes the frame; that same
                    // edge parks sclk low and raises cs_n.
                    if (sclk_fall) begin
                        if (rise_cnt_q == 5'(FRAME_W)) begin
                            state_q    <= ST_GAP;
                            shreg_q    <= '0;
                            rise_cnt_q <= '0;
                            gap_q      <= '0;
                            cs_n_q     <= 1'b1;
                            if (GAP_CYC == 1) done_q <= 1'b1;
                        end else begin
                            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == DIV_W'(GAP_CYC - 1)) begin
                        state_q <= ST_IDLE;
                        gap_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + DIV_W'(1);
                        // done_q is registered, so raise it one cycle early
                        if (GAP_CYC >= 2 && gap_q == DIV_W'(GAP_CYC - 2)) done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    shreg_q <= '0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign cs_n_o  = cs_n_q;
    assign mosi_o  = shreg_q[FRAME_W-1];

endmodule
